wb_ram_responder: RTL and testbench
===================================

// Module: wb_ram_responder
//
// PURPOSE
// Pipelined Wishbone (B4, pipelined mode) slave backed by on-chip block RAM. Answers the same
// bus that serial_wb_master drives, as a drop-in substitute for wb_sdram on boards without
// SDRAM and in simulation. Configurable ack latency, outstanding-request limit and periodic
// stall injection exercise master-side stall/ack handling.
//
// PARAMETERS
// BYTES           2   data bus width in bytes; word-addressed, one sel bit per byte
// ADDR_BITS       10  word address width; memory depth = 2**ADDR_BITS words
// LATENCY         2   cycles from request accept to ack (>=1)
// MAX_OUTSTANDING 4   accepted-but-unacked limit (>=1); stall while at limit
// STALL_PERIOD    0   0 = no injected stall; N>=2 = stall forced high 1 cycle in every N
//
// PORTS
// clk          in   1          clock
// areset       in   1          asynchronous reset, active high
// s_wb_cyc     in   1          bus cycle active
// s_wb_stb     in   1          request strobe
// s_wb_we      in   1          1 = write, 0 = read
// s_wb_addr    in   ADDR_BITS  word address
// s_wb_sel     in   BYTES      byte-lane enables (writes only)
// s_wb_dat_m2s in   BYTES*8    write data
// s_wb_ack     out  1          response strobe, one per accepted request
// s_wb_stall   out  1          request not accepted this cycle
// s_wb_dat_s2m out  BYTES*8    read data, valid with ack
//
// BEHAVIOUR
// - Reset (async assert, sync release): ack=0, dat_s2m=0, stall=0, outstanding=0, ack
//   pipeline cleared, stall-pattern counter=0. Memory contents NOT reset.
// - Accept: cyc && stb && !stall on a rising edge. stall depends on registered state only
//   (no combinational path from stb/cyc/addr).
// - Write: on accept, lanes with sel[i]=1 written; others unchanged. sel=0 still acked.
// - Read: memory sampled at accept. Write accepted cycle T visible to read accepted T+1.
// - Ack: exactly LATENCY cycles after accept, strictly in order; one ack per request,
//   one-cycle pulse. Back-to-back accepts give back-to-back acks.
// - dat_s2m = read word when ack for a read; 0 otherwise (incl. write acks).
// - Outstanding count: +1 on accept, -1 on ack, unchanged if both same cycle.
// - stall = (outstanding == MAX_OUTSTANDING && no ack this cycle) || inject, where inject
//   is high when the free-running counter (mod STALL_PERIOD) equals STALL_PERIOD-1.
//   Count/pattern recomputed from registered state, so stall may drop the cycle an ack fires.
// - cyc low: all in-flight acks discarded (pipeline valids cleared, count->0) in that cycle;
//   accepted writes remain committed. stb without cyc ignored.
// - Reset mid-operation: pending acks lost; writes already committed remain.
// - Elaboration error if LATENCY<1, MAX_OUTSTANDING<1 or STALL_PERIOD==1.
//
// TESTING
// 1. Defaults; write 0xBEEF @5 sel=11, read @5 -> ack 2 cycles after accept, dat_s2m=0xBEEF.
// 2. Write 0x1234 @5 sel=01 after 1 -> read @5 returns 0xBE34; write ack has dat_s2m=0.
// 3. 8 consecutive reads @0..7 (prefilled 0x100+i), LATENCY=2, MAX_OUTSTANDING=4 -> no
//    stall, 8 consecutive acks starting 2 cycles after first accept, data 0x100..0x107.
// 4. LATENCY=3, MAX_OUTSTANDING=1, stb held -> one accept every 3 cycles, stall high 2 of 3.
// 5. STALL_PERIOD=4, stb held -> stall high every 4th cycle only; acks match accepts 1:1.
// 6. Drop cyc with 2 in flight -> no further acks, count 0; written data reads back later.
// 7. Assert areset mid-burst -> ack/stall/dat_s2m 0 immediately; memory preserved after.

Source files
------------

// File: rtl/wb_ram_responder_if.sv
// Pipelined Wishbone B4 bus bundle between a master and the block-RAM responder.
interface wb_ram_responder_if #(
  parameter int BYTES     = 2,
  parameter int ADDR_BITS = 10
);
  logic                 cyc;
  logic                 stb;
  logic                 we;
  logic [ADDR_BITS-1:0] addr;
  logic [BYTES-1:0]     sel;
  logic [BYTES*8-1:0]   dat_m2s;
  logic                 ack;
  logic                 stall;
  logic [BYTES*8-1:0]   dat_s2m;

  modport master (
    output cyc, stb, we, addr, sel, dat_m2s,
    input  ack, stall, dat_s2m
  );

  modport slave (
    input  cyc, stb, we, addr, sel, dat_m2s,
    output ack, stall, dat_s2m
  );
endinterface

// File: rtl/wb_ram_responder.sv
// Pipelined Wishbone slave on block RAM with fixed ack latency, an outstanding-request
// limit and optional periodic stall injection to exercise master stall/ack handling.
module wb_ram_responder #(
  parameter int BYTES           = 2,
  parameter int ADDR_BITS       = 10,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STALL_PERIOD    = 0
) (
  input  logic                clk,
  input  logic                areset,
  wb_ram_responder_if.slave   s_wb
);
  localparam int DW = BYTES * 8;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [PW-1:0] PAT_LAST = PW'((STALL_PERIOD > 1) ? STALL_PERIOD - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);

  if (LATENCY < 1) begin : g_bad_latency
    $error("wb_ram_responder: LATENCY must be >= 1");
  end
  if (MAX_OUTSTANDING < 1) begin : g_bad_outstanding
    $error("wb_ram_responder: MAX_OUTSTANDING must be >= 1");
  end
  if (STALL_PERIOD == 1) begin : g_bad_stall_period
    $error("wb_ram_responder: STALL_PERIOD must be 0 or >= 2");
  end

  logic [DW-1:0]      mem [2**ADDR_BITS];

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] wr_q, wr_d;
  logic [DW-1:0]      dat_q [LATENCY];
  logic [DW-1:0]      dat_d [LATENCY];
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      pat_q, pat_d;

  logic accept;
  logic ack_fire;
  logic inject;
  logic stall;

  // stall is a function of registered state only, so a master may loop it back freely
  assign ack_fire = vld_q[LATENCY-1];
  assign inject   = (STALL_PERIOD > 1) && (pat_q == PAT_LAST);
  assign stall    = ((cnt_q == CNT_MAX) && !ack_fire) || inject;
  assign accept   = s_wb.cyc && s_wb.stb && !stall;

  always_comb begin
    vld_d    = '0;
    wr_d     = '0;
    for (int i = 0; i < LATENCY; i++) dat_d[i] = '0;
    cnt_d    = cnt_q;
    pat_d    = '0;

    vld_d[0] = accept;
    wr_d[0]  = accept && s_wb.we;
    dat_d[0] = (accept && !s_wb.we) ? mem[s_wb.addr] : '0;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      wr_d[i]  = wr_q[i-1];
      dat_d[i] = dat_q[i-1];
    end

    if (s_wb.cyc) begin
      cnt_d = cnt_q + CW'(accept) - CW'(ack_fire);
    end else begin
      vld_d = '0;
      cnt_d = '0;
    end

    if (STALL_PERIOD > 1) pat_d = inject ? '0 : pat_q + 1'b1;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      vld_q <= '0;
      wr_q  <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
      cnt_q <= '0;
      pat_q <= '0;
    end else begin
      vld_q <= vld_d;
      wr_q  <= wr_d;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= dat_d[i];
      cnt_q <= cnt_d;
      pat_q <= pat_d;
    end
  end

  // Memory is deliberately outside the reset domain so contents survive areset
  always_ff @(posedge clk) begin
    if (accept && s_wb.we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (s_wb.sel[i]) mem[s_wb.addr][i*8 +: 8] <= s_wb.dat_m2s[i*8 +: 8];
      end
    end
  end

  assign s_wb.ack     = ack_fire && s_wb.cyc;
  assign s_wb.stall   = stall;
  assign s_wb.dat_s2m = (s_wb.ack && !wr_q[LATENCY-1]) ? dat_q[LATENCY-1] : '0;
endmodule

// File: tb/tb_wb_ram_responder.sv
// Directed bench for wb_ram_responder: default, latency/limit and stall-injection builds.
module tb_wb_ram_responder;
  logic clk = 1'b0;
  logic areset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  wb_ram_responder_if #(.BYTES(2), .ADDR_BITS(10)) bus_a ();
  wb_ram_responder_if #(.BYTES(2), .ADDR_BITS(10)) bus_b ();
  wb_ram_responder_if #(.BYTES(2), .ADDR_BITS(10)) bus_c ();

  wb_ram_responder #(.BYTES(2), .ADDR_BITS(10), .LATENCY(2), .MAX_OUTSTANDING(4),
                     .STALL_PERIOD(0)) dut_a (.clk(clk), .areset(areset), .s_wb(bus_a));
  wb_ram_responder #(.BYTES(2), .ADDR_BITS(10), .LATENCY(3), .MAX_OUTSTANDING(1),
                     .STALL_PERIOD(0)) dut_b (.clk(clk), .areset(areset), .s_wb(bus_b));
  wb_ram_responder #(.BYTES(2), .ADDR_BITS(10), .LATENCY(2), .MAX_OUTSTANDING(4),
                     .STALL_PERIOD(4)) dut_c (.clk(clk), .areset(areset), .s_wb(bus_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single read on bus_a from an idle pipeline; reports data and whether ack timing held.
  task automatic a_read(input logic [9:0] addr, output logic [15:0] data, output bit ack_ok);
    bus_a.cyc = 1'b1; bus_a.stb = 1'b1; bus_a.we = 1'b0;
    bus_a.addr = addr; bus_a.sel = 2'b00; bus_a.dat_m2s = '0;
    step();
    bus_a.stb = 1'b0;
    ack_ok = (bus_a.ack === 1'b0);
    step();
    ack_ok = ack_ok && (bus_a.ack === 1'b1);
    data = bus_a.dat_s2m;
    step();
    ack_ok = ack_ok && (bus_a.ack === 1'b0);
  endtask

  task automatic a_write(input logic [9:0] addr, input logic [15:0] data, input logic [1:0] sel);
    bus_a.cyc = 1'b1; bus_a.stb = 1'b1; bus_a.we = 1'b1;
    bus_a.addr = addr; bus_a.sel = sel; bus_a.dat_m2s = data;
    step();
    bus_a.stb = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus_a.ack !== 1'b0 || bus_a.stall !== 1'b0 || bus_a.dat_s2m !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_a: ack=%b stall=%b dat=%h, want 0 0 0000", bus_a.ack, bus_a.stall, bus_a.dat_s2m);
    end
    n_checks++;
    if (bus_b.ack !== 1'b0 || bus_b.stall !== 1'b0 || bus_c.ack !== 1'b0 || bus_c.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bc: b ack=%b stall=%b c ack=%b stall=%b, want all 0",
               bus_b.ack, bus_b.stall, bus_c.ack, bus_c.stall);
    end
    n_checks++;
    if (dut_a.cnt_q !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d want 0", dut_a.cnt_q);
    end
  endtask

  task automatic test_write_read();
    logic [15:0] wdat [2] = '{16'hBEEF, 16'h1234};
    logic [1:0]  wsel [2] = '{2'b11, 2'b01};
    logic [15:0] rexp [2] = '{16'hBEEF, 16'hBE34};
    for (int v = 0; v < 2; v++) begin
      bus_a.cyc = 1'b1; bus_a.stb = 1'b1; bus_a.we = 1'b1;
      bus_a.addr = 10'd5; bus_a.sel = wsel[v]; bus_a.dat_m2s = wdat[v];
      n_checks++;
      if (bus_a.stall !== 1'b0) begin
        n_fail++; $display("FAIL wr_stall[%0d]: got %b want 0", v, bus_a.stall);
      end
      step();
      n_checks++;
      if (bus_a.ack !== 1'b0) begin
        n_fail++; $display("FAIL wr_ack_early[%0d]: got %b want 0", v, bus_a.ack);
      end
      bus_a.we = 1'b0; bus_a.sel = 2'b00; bus_a.dat_m2s = 16'hFFFF;
      step();
      bus_a.stb = 1'b0;
      n_checks++;
      if (bus_a.ack !== 1'b1 || bus_a.dat_s2m !== 16'h0) begin
        n_fail++;
        $display("FAIL wr_ack[%0d]: ack=%b dat=%h want 1 0000", v, bus_a.ack, bus_a.dat_s2m);
      end
      step();
      n_checks++;
      if (bus_a.ack !== 1'b1 || bus_a.dat_s2m !== rexp[v]) begin
        n_fail++;
        $display("FAIL rd_ack[%0d]: ack=%b dat=%h want 1 %h", v, bus_a.ack, bus_a.dat_s2m, rexp[v]);
      end
      step();
      n_checks++;
      if (bus_a.ack !== 1'b0 || bus_a.dat_s2m !== 16'h0) begin
        n_fail++;
        $display("FAIL rd_ack_pulse[%0d]: ack=%b dat=%h want 0 0000", v, bus_a.ack, bus_a.dat_s2m);
      end
    end
  endtask

  task automatic test_back_to_back();
    bus_a.cyc = 1'b1; bus_a.we = 1'b1; bus_a.sel = 2'b11;
    for (int i = 0; i < 8; i++) begin
      bus_a.stb = 1'b1; bus_a.addr = 10'(i); bus_a.dat_m2s = 16'(16'h100 + i);
      n_checks++;
      if (bus_a.stall !== 1'b0) begin
        n_fail++; $display("FAIL prefill_stall[%0d]: got %b want 0", i, bus_a.stall);
      end
      step();
    end
    bus_a.stb = 1'b0;
    repeat (3) step();
    bus_a.we = 1'b0; bus_a.sel = 2'b00;
    for (int c = 0; c < 12; c++) begin
      if (c >= 2 && c < 10) begin
        n_checks++;
        if (bus_a.ack !== 1'b1 || bus_a.dat_s2m !== 16'(16'h100 + c - 2)) begin
          n_fail++;
          $display("FAIL b2b_ack[%0d]: ack=%b dat=%h want 1 %h", c, bus_a.ack, bus_a.dat_s2m,
                   16'(16'h100 + c - 2));
        end
      end else begin
        n_checks++;
        if (bus_a.ack !== 1'b0) begin
          n_fail++; $display("FAIL b2b_noack[%0d]: got %b want 0", c, bus_a.ack);
        end
      end
      if (c < 8) begin
        bus_a.stb = 1'b1; bus_a.addr = 10'(c);
        n_checks++;
        if (bus_a.stall !== 1'b0) begin
          n_fail++; $display("FAIL b2b_stall[%0d]: got %b want 0", c, bus_a.stall);
        end
      end else begin
        bus_a.stb = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_outstanding_limit();
    bus_b.cyc = 1'b1; bus_b.we = 1'b1; bus_b.addr = 10'd9;
    bus_b.sel = 2'b11; bus_b.dat_m2s = 16'h0009;
    for (int c = 0; c < 12; c++) begin
      n_checks++;
      if (bus_b.stall !== (c != 0 && c % 3 != 0)) begin
        n_fail++;
        $display("FAIL limit_stall[%0d]: got %b want %b", c, bus_b.stall, (c != 0 && c % 3 != 0));
      end
      n_checks++;
      if (bus_b.ack !== (c >= 3 && c % 3 == 0)) begin
        n_fail++;
        $display("FAIL limit_ack[%0d]: got %b want %b", c, bus_b.ack, (c >= 3 && c % 3 == 0));
      end
      if (c == 0) bus_b.stb = 1'b1;
      step();
    end
    bus_b.stb = 1'b0; bus_b.cyc = 1'b0;
  endtask

  task automatic test_stall_inject();
    int seen = -1;
    int acks = 0;
    bus_c.cyc = 1'b1; bus_c.stb = 1'b0; bus_c.we = 1'b1;
    bus_c.addr = 10'd20; bus_c.sel = 2'b11; bus_c.dat_m2s = 16'h0020;
    for (int i = 0; i < 8 && seen < 0; i++) begin
      step();
      if (bus_c.stall === 1'b1) seen = i;
    end
    n_checks++;
    if (seen < 0) begin
      n_fail++; $display("FAIL inject_found: no stall within 8 cycles, want one");
    end else begin
      for (int c = 1; c <= 20; c++) begin
        step();
        n_checks++;
        if (bus_c.stall !== (c % 4 == 0)) begin
          n_fail++; $display("FAIL inject_stall[%0d]: got %b want %b", c, bus_c.stall, (c % 4 == 0));
        end
        if (bus_c.ack === 1'b1) acks++;
        bus_c.stb = (c <= 12);
      end
      n_checks++;
      if (acks != 9) begin
        n_fail++; $display("FAIL inject_acks: got %0d want 9", acks);
      end
    end
    bus_c.stb = 1'b0; bus_c.cyc = 1'b0;
  endtask

  task automatic test_cyc_drop();
    logic [15:0] d;
    bit ok;
    bus_a.cyc = 1'b1; bus_a.stb = 1'b1; bus_a.we = 1'b1; bus_a.sel = 2'b11;
    bus_a.addr = 10'd7; bus_a.dat_m2s = 16'h5A5A;
    step();
    bus_a.addr = 10'd8; bus_a.dat_m2s = 16'hC3C3;
    step();
    bus_a.cyc = 1'b0; bus_a.stb = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (bus_a.ack !== 1'b0) begin
        n_fail++; $display("FAIL drop_ack[%0d]: got %b want 0", c, bus_a.ack);
      end
      step();
    end
    n_checks++;
    if (dut_a.cnt_q !== 3'd0) begin
      n_fail++; $display("FAIL drop_count: got %0d want 0", dut_a.cnt_q);
    end
    a_read(10'd7, d, ok);
    n_checks++;
    if (!ok || d !== 16'h5A5A) begin
      n_fail++; $display("FAIL drop_read7: ack_ok=%0d dat=%h want 1 5a5a", ok, d);
    end
    a_read(10'd8, d, ok);
    n_checks++;
    if (!ok || d !== 16'hC3C3) begin
      n_fail++; $display("FAIL drop_read8: ack_ok=%0d dat=%h want 1 c3c3", ok, d);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    bit ok;
    a_write(10'd10, 16'h7777, 2'b11);
    bus_a.cyc = 1'b1; bus_a.stb = 1'b1; bus_a.we = 1'b0; bus_a.addr = 10'd10; bus_a.sel = 2'b00;
    step();
    step();
    n_checks++;
    if (bus_a.ack !== 1'b1 || bus_a.dat_s2m !== 16'h7777) begin
      n_fail++; $display("FAIL mid_pre_ack: ack=%b dat=%h want 1 7777", bus_a.ack, bus_a.dat_s2m);
    end
    #2 areset = 1'b1;
    #1;
    n_checks++;
    if (bus_a.ack !== 1'b0 || bus_a.stall !== 1'b0 || bus_a.dat_s2m !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_reset: ack=%b stall=%b dat=%h want 0 0 0000", bus_a.ack, bus_a.stall, bus_a.dat_s2m);
    end
    bus_a.stb = 1'b0; bus_a.cyc = 1'b0;
    step();
    n_checks++;
    if (bus_a.ack !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_held: ack=%b want 0", bus_a.ack);
    end
    areset = 1'b0;
    step();
    a_read(10'd10, d, ok);
    n_checks++;
    if (!ok || d !== 16'h7777) begin
      n_fail++; $display("FAIL mid_mem_kept: ack_ok=%0d dat=%h want 1 7777", ok, d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    areset = 1'b1;
    bus_a.cyc = 1'b0; bus_a.stb = 1'b0; bus_a.we = 1'b0; bus_a.addr = '0; bus_a.sel = '0; bus_a.dat_m2s = '0;
    bus_b.cyc = 1'b0; bus_b.stb = 1'b0; bus_b.we = 1'b0; bus_b.addr = '0; bus_b.sel = '0; bus_b.dat_m2s = '0;
    bus_c.cyc = 1'b0; bus_c.stb = 1'b0; bus_c.we = 1'b0; bus_c.addr = '0; bus_c.sel = '0; bus_c.dat_m2s = '0;
    step();
    step();
    test_reset();
    areset = 1'b0;
    step();
    test_write_read();
    test_back_to_back();
    test_outstanding_limit();
    test_stall_inject();
    test_cyc_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
